// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding memory requester feeding a
// small in-order instruction buffer, with branch redirect and stale-response drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_resp_valid,
    input  logic [31:0] i_imem_resp_data,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready,
    input  logic        i_b_taken,
    input  logic [31:0] i_b_pc
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   buf_instr_q [BUF_DEPTH];
    logic [31:0]   buf_pc_q    [BUF_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic req_valid, req_hs, instr_valid, push, pop, resp;

    assign resp        = i_imem_resp_valid && !i_reset;
    assign req_hs      = req_valid && i_imem_req_ready;
    assign instr_valid = !i_reset && (count_q != '0);
    assign pop         = instr_valid && i_instr_ready;
    assign push        = (state_q == S_WAIT) && resp && !i_b_taken;

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= S_REQ;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_b_taken) begin
            // A redirect leaves an in-flight request as stale; a response that
            // lands in the redirect cycle retires it immediately.
            case (state_q)
                S_REQ:   state_d = req_hs ? S_DROP : S_REQ;
                S_WAIT:  state_d = resp ? S_REQ : S_DROP;
                S_DROP:  state_d = resp ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ:   state_d = req_hs ? S_WAIT : S_REQ;
                S_WAIT:  state_d = resp ? S_REQ : S_WAIT;
                S_DROP:  state_d = resp ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_comb begin
        req_valid = 1'b0;
        if (!i_reset && state_q == S_REQ && count_q < DEPTH_C) req_valid = 1'b1;
        o_imem_req_valid = req_valid;
        o_imem_addr      = i_reset ? RESET_PC : fetch_pc_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (req_hs) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (i_b_taken) begin
            fetch_pc_d = i_b_pc & 32'hFFFF_FFFC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible while count is nonzero.
    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= i_imem_resp_data;
            buf_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    assign o_instr_valid = instr_valid;
    assign o_instr       = instr_valid ? buf_instr_q[rd_ptr_q] : '0;
    assign o_instr_pc    = instr_valid ? buf_pc_q[rd_ptr_q]    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based reference model checked every
// cycle, a latency-programmable memory responder, and literal scenario checks.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        iv;
    logic [31:0] instr, ipc;
    logic        iready = 1'b0;
    logic        b_taken = 1'b0;
    logic [31:0] b_pc = '0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(rst_in),
        .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready),
        .o_imem_addr(addr),
        .i_imem_resp_valid(resp_valid), .i_imem_resp_data(resp_data),
        .o_instr_valid(iv), .o_instr(instr), .o_instr_pc(ipc),
        .i_instr_ready(iready),
        .i_b_taken(b_taken), .i_b_pc(b_pc)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_req_pc = '0;
    int          m_out = 0;   // 0 none, 1 live, 2 stale

    int          lat = 1;
    bit          mem_pend = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    ent_t        pops[$];
    int          hs_cnt = 0;
    bit          s_req, s_iv;
    logic [31:0] s_addr, s_ipc;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0] + 16'h1357};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rst, input bit rdy, input bit ird, input bit bt,
                       input logic [31:0] bpc);
        bit          e_req, e_iv, resp;
        logic [31:0] e_instr, e_ipc, e_addr, rdata;
        ent_t        e;
        @(negedge clk);
        rst_in = rst; req_ready = rdy; iready = ird; b_taken = bt; b_pc = bpc;
        if (rst) begin
            resp = 1'b1; rdata = 32'hDEAD_BEEF;
        end else if (mem_pend && mem_cnt == 0) begin
            resp = 1'b1; rdata = memf(mem_addr);
        end else begin
            resp = 1'b0; rdata = $urandom;
        end
        resp_valid = resp; resp_data = rdata;
        #1;
        e_req   = !rst && m_out == 0 && mq.size() < DEPTH;
        e_iv    = !rst && mq.size() != 0;
        e_instr = '0; e_ipc = '0;
        if (e_iv) begin e_instr = mq[0].data; e_ipc = mq[0].pc; end
        e_addr  = rst ? RST_PC : m_pc;
        chk("req_valid", {31'd0, req_valid}, {31'd0, e_req});
        chk("imem_addr", addr, e_addr);
        chk("instr_valid", {31'd0, iv}, {31'd0, e_iv});
        chk("instr", instr, e_instr);
        chk("instr_pc", ipc, e_ipc);
        s_req = req_valid; s_iv = iv; s_addr = addr; s_ipc = ipc;
        if (iv && ird && !rst) begin e.pc = ipc; e.data = instr; pops.push_back(e); end
        if (req_valid && rdy && !rst) hs_cnt++;
        // reference model
        if (rst) begin
            m_pc = RST_PC; mq.delete(); m_out = 0;
        end else begin
            if (e_iv && ird) void'(mq.pop_front());
            if (resp && m_out == 1 && !bt) begin
                e.pc = m_req_pc; e.data = rdata; mq.push_back(e);
            end
            if (resp) m_out = 0;
            if (e_req && rdy) begin m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_out = 1; end
            if (bt) begin
                mq.delete(); m_pc = {bpc[31:2], 2'b00};
                if (m_out == 1) m_out = 2;
            end
        end
        // memory responder (reset together with the fetch unit)
        if (rst) mem_pend = 0;
        else begin
            if (resp) mem_pend = 0;
            else if (mem_pend) mem_cnt--;
            if (req_valid && rdy) begin mem_pend = 1; mem_cnt = lat - 1; mem_addr = addr; end
        end
    endtask

    task automatic do_reset();
        repeat (3) cyc(1, 1, 1, 1, 32'h500);
        chk("reset req_valid", {31'd0, s_req}, 32'd0);
        chk("reset instr_valid", {31'd0, s_iv}, 32'd0);
        chk("reset addr", s_addr, RST_PC);
    endtask

    task automatic wait_req(input int max, input bit ird);
        bit ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            cyc(0, 0, ird, 0, 32'h0);
            ok = s_req;
        end
        chk("wait_req timeout", {31'd0, ok}, 32'd1);
    endtask

    function automatic bit popped(input logic [31:0] pc);
        foreach (pops[i]) if (pops[i].pc == pc) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        // sequential fetch, latency 1
        do_reset();
        lat = 1; pops.delete();
        cyc(0, 1, 1, 0, 0);
        chk("first req after reset", {31'd0, s_req}, 32'd1);
        repeat (7) cyc(0, 1, 1, 0, 0);
        chk("seq pop count", {31'd0, pops.size() >= 3}, 32'd1);
        if (pops.size() >= 3) begin
            chk("seq pc0", pops[0].pc, 32'h0);
            chk("seq pc1", pops[1].pc, 32'h4);
            chk("seq pc2", pops[2].pc, 32'h8);
            chk("seq data0", pops[0].data, 32'hC0DE_1357);
            chk("seq data1", pops[1].data, 32'hC0DA_135B);
        end

        // full buffer
        do_reset();
        lat = 1; hs_cnt = 0;
        repeat (10) cyc(0, 1, 0, 0, 0);
        chk("full hs count", hs_cnt, 32'd2);
        chk("full req low", {31'd0, s_req}, 32'd0);
        cyc(0, 1, 1, 0, 0);
        hs_cnt = 0;
        cyc(0, 1, 0, 0, 0);
        chk("refill req", {31'd0, s_req}, 32'd1);
        chk("refill addr", s_addr, 32'h8);
        repeat (6) cyc(0, 1, 0, 0, 0);
        chk("refill hs count", hs_cnt, 32'd1);

        // simultaneous push and pop at count 1
        do_reset();
        lat = 1; pops.delete();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("pp head pc before", s_ipc, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("pp valid after", {31'd0, s_iv}, 32'd1);
        chk("pp head pc after", s_ipc, 32'h4);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("pp count was 1", {31'd0, s_iv}, 32'd0);
        cyc(0, 0, 1, 0, 0);
        chk("pp order size", pops.size(), 32'd3);
        if (pops.size() == 3) begin
            chk("pp order 0", pops[0].pc, 32'h0);
            chk("pp order 1", pops[1].pc, 32'h4);
            chk("pp order 2", pops[2].pc, 32'h8);
        end

        // redirect in WAIT
        do_reset();
        lat = 3;
        repeat (12) cyc(0, 1, 0, 0, 0);
        chk("wait full req low", {31'd0, s_req}, 32'd0);
        cyc(0, 1, 1, 0, 0);
        pops.delete();
        cyc(0, 1, 0, 0, 0);
        chk("wait req 8", s_addr, 32'h8);
        chk("wait req 8 valid", {31'd0, s_req}, 32'd1);
        cyc(0, 1, 0, 1, 32'h100);
        chk("wait pre-flush valid", {31'd0, s_iv}, 32'd1);
        cyc(0, 1, 0, 0, 0);
        chk("wait flushed", {31'd0, s_iv}, 32'd0);
        chk("wait drop no req", {31'd0, s_req}, 32'd0);
        wait_req(10, 0);
        chk("wait redirect addr", s_addr, 32'h100);
        repeat (10) cyc(0, 1, 1, 0, 0);
        chk("wait stale 8 dropped", {31'd0, popped(32'h8)}, 32'd0);
        chk("wait first after redirect", (pops.size() > 0) ? pops[0].pc : 32'hFFFF_FFFF, 32'h100);

        // redirect on the handshake cycle, then back-to-back redirects
        do_reset();
        lat = 2; pops.delete();
        cyc(0, 1, 1, 1, 32'h202);
        chk("hs redirect req", {31'd0, s_req}, 32'd1);
        chk("hs redirect addr", s_addr, 32'h0);
        cyc(0, 1, 1, 0, 0);
        chk("drop no req", {31'd0, s_req}, 32'd0);
        wait_req(10, 1);
        chk("aligned target", s_addr, 32'h200);
        repeat (8) cyc(0, 1, 1, 0, 0);
        chk("stale 0 dropped", {31'd0, popped(32'h0)}, 32'd0);
        chk("first after drop", (pops.size() > 0) ? pops[0].pc : 32'hFFFF_FFFF, 32'h200);
        repeat (6) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 32'h300);
        cyc(0, 0, 1, 1, 32'h404);
        wait_req(5, 1);
        chk("last redirect wins", s_addr, 32'h404);

        // reset while a request is outstanding
        do_reset();
        lat = 3;
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("post-reset instr_valid", {31'd0, s_iv}, 32'd0);
        chk("post-reset req", {31'd0, s_req}, 32'd1);
        chk("post-reset addr", s_addr, RST_PC);
        repeat (8) cyc(0, 1, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have parameter BUF_DEPTH, default 2, giving the instruction buffer entry count; legal values are 2 and 4.
REQ-003 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-004 The module SHALL have these ports:
 - i_clk  in  1  clock.
 - i_reset  in  1  synchronous active-high reset.
 - o_imem_req_valid  out  1  fetch request valid.
 - i_imem_req_ready  in  1  memory accepts request.
 - o_imem_addr  out  32  fetch address, word aligned.
 - i_imem_resp_valid  in  1  response data valid; no backpressure.
 - i_imem_resp_data  in  32  instruction word.
 - o_instr_valid  out  1  buffer head valid to decode.
 - o_instr  out  32  buffer head instruction.
 - o_instr_pc  out  32  PC of o_instr.
 - i_instr_ready  in  1  decode consumes head.
 - i_b_taken  in  1  redirect from the branch unit.
 - i_b_pc  in  32  redirect target.

Function
REQ-005 The module SHALL keep fetch_pc, the address of the next request, and SHALL advance it by 4 (mod 2^32) on each request handshake (valid and ready).
REQ-006 The module SHALL allow at most one outstanding memory request.
 - Memory responds in order.
 - The response arrives at least 1 cycle after the handshake.
REQ-007 The FSM SHALL have three states:
 - REQ: request permitted.
 - WAIT: one live request outstanding.
 - DROP: one stale request outstanding.
REQ-008 In REQ, o_imem_req_valid SHALL be asserted with o_imem_addr = fetch_pc when buffer count < BUF_DEPTH; otherwise it SHALL stay low.
REQ-009 A handshake in REQ SHALL move the FSM to WAIT and record req_pc = fetch_pc.
REQ-010 Once o_imem_req_valid is asserted, it and o_imem_addr SHALL stay stable until handshake, except in a redirect cycle.
REQ-011 In WAIT, i_imem_resp_valid SHALL push {i_imem_resp_data, req_pc} into the buffer and move the FSM to REQ.
REQ-012 In DROP, i_imem_resp_valid SHALL discard the data and move the FSM to REQ.
REQ-013 Responses arriving in REQ SHALL be ignored.
REQ-014 The buffer SHALL be a FIFO; its head drives o_instr and o_instr_pc, and o_instr_valid = (count != 0).
REQ-015 A pop SHALL occur when o_instr_valid and i_instr_ready are both high.
REQ-016 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-017 When count = 0, a push SHALL make the entry visible on the outputs the next cycle; there is no same-cycle bypass.
REQ-018 A redirect (i_b_taken = 1) SHALL take priority over every other event in that cycle:
 - fetch_pc <= {i_b_pc[31:2], 2'b00}.
 - The buffer is flushed (count <= 0); any push in that cycle is suppressed.
 - A pop handshake in that cycle is still counted as consumed.
REQ-019 The next FSM state after a redirect SHALL be:
 - DROP, if the FSM is in WAIT with no response this cycle, or in REQ with a handshake this cycle.
 - REQ otherwise, including WAIT with a response this cycle, which is discarded.
REQ-020 A redirect in DROP SHALL keep the FSM in DROP and update fetch_pc.
REQ-021 Back-to-back redirects SHALL each overwrite fetch_pc; the last one wins.
REQ-022 Fetch-to-decode latency SHALL be: request handshake at cycle t, response at t+k (k >= 1), o_instr_valid at t+k+1.
REQ-023 The buffer SHALL never overflow: a request is issued only when count < BUF_DEPTH and only one request is in flight.

Reset
REQ-024 While i_reset = 1, the module SHALL hold:
 - fetch_pc = RESET_PC, count = 0, state = REQ.
 - o_imem_req_valid = 0, o_instr_valid = 0, o_instr = 0, o_instr_pc = 0, o_imem_addr = RESET_PC.
REQ-025 i_imem_resp_valid and i_b_taken SHALL be ignored during reset.
REQ-026 Instruction memory SHALL be reset by the same i_reset, so no response survives reset.
REQ-027 The first request SHALL be asserted in the first cycle after i_reset deasserts.

Verification
REQ-028 Reset then sequential fetch: ready = 1, response latency 1, i_instr_ready = 1 -> o_instr_pc sequence 0x0, 0x4, 0x8; o_instr equals memory data.
REQ-029 Full buffer: i_instr_ready = 0 with BUF_DEPTH = 2 -> exactly 2 handshakes, then o_imem_req_valid = 0; one pop -> one new request.
REQ-030 Redirect in WAIT: request 0x8 outstanding, i_b_taken = 1 with i_b_pc = 0x100 -> the 0x8 response is discarded, the buffer is emptied, and the next request address is 0x100.
REQ-031 Redirect in the same cycle as the request handshake: FSM enters DROP, the stale response is dropped, then 0x200 is fetched for i_b_pc = 0x202 (aligned).
REQ-032 Simultaneous push and pop with count = 1 -> count stays 1 and order is preserved (pc 0x4 out before 0x8).
REQ-033 Reset asserted in WAIT -> the next cycle shows o_instr_valid = 0, and the first request after reset is at RESET_PC.
